// File: rtl/cpu_axi_pkg.sv
// Shared AXI read-channel constants, prefetch FSM states and FIFO entry
// layout used by inst_prefetch and ipf_fifo.
package cpu_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DATA  = 2'd2,
    S_DRAIN = 2'd3
  } ipf_state_e;

  // One prefetched word: its PC, the instruction and the beat error flag.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } ipf_entry_t;

  // ARLEN that stops the burst at the next BURST_LEN-word aligned boundary.
  function automatic logic [7:0] burst_arlen(input logic [31:0] addr,
                                             input int unsigned blen);
    logic [31:0] w_off;
    w_off = (addr >> 2) & (blen - 1);
    return 8'(blen - 1 - w_off);
  endfunction

endpackage

// File: rtl/ipf_fifo.sv
// Synchronous FIFO for prefetched entries with push/pop/flush and an
// occupancy count. Flush has priority over push and pop.
module ipf_fifo
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 65
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);
  assign o_data    = r_mem[r_rptr];
  assign o_count   = r_count;

  // Pointer and occupancy tracking; flush empties the queue in one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful below the count.
  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) r_mem[r_wptr] <= i_data;
  end

  // Issue logic only starts a burst with BURST_LEN free slots, so a push
  // into a full FIFO without a matching pop means the controller is broken.
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_push && !i_flush && w_full && !i_pop));

endmodule

// File: rtl/inst_prefetch.sv
// RV32I instruction prefetch unit: issues aligned INCR bursts on AXI AR/R,
// buffers {pc, inst, err} in ipf_fifo and presents the head to decode.
// Optional build macro: IPF_ZERO_SQUASH_EN -- drop all-zero instruction
// words at the FIFO output instead of delivering them.
module inst_prefetch
  import cpu_axi_pkg::*;
#(
  parameter int unsigned C_M_AXI_THREAD_ID_WIDTH = 1,
  parameter int unsigned C_M_AXI_ADDR_WIDTH      = 32,
  parameter int unsigned FIFO_DEPTH              = 16,
  parameter int unsigned BURST_LEN               = 4,
  parameter logic [31:0] RESET_PC                = 32'h2000_0000
) (
  input  logic                               CLK,
  input  logic                               RSTN,
  input  logic                               EXEC,
  input  logic                               STALL,
  input  logic                               REDIRECT,
  input  logic [31:0]                        REDIRECT_PC,
  output logic                               MEM_WAIT,
  output logic [31:0]                        I_PC,
  output logic [31:0]                        I_INST,
  output logic                               I_ERR,
  output logic                               I_VALID,
  output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_ARADDR,
  output logic [7:0]                         M_AXI_ARLEN,
  output logic [2:0]                         M_AXI_ARSIZE,
  output logic [1:0]                         M_AXI_ARBURST,
  output logic                               M_AXI_ARLOCK,
  output logic [3:0]                         M_AXI_ARCACHE,
  output logic [2:0]                         M_AXI_ARPROT,
  output logic                               M_AXI_ARVALID,
  input  logic                               M_AXI_ARREADY,
  input  logic [31:0]                        M_AXI_RDATA,
  input  logic [1:0]                         M_AXI_RRESP,
  input  logic                               M_AXI_RLAST,
  input  logic                               M_AXI_RVALID,
  output logic                               M_AXI_RREADY
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  ipf_state_e  r_state;
  ipf_state_e  w_next;
  logic [31:0] r_fa;
  logic [31:0] r_araddr;
  logic [7:0]  r_arlen;
  logic        r_drain_pend;
  logic        w_push;
  logic        w_pop;
  logic        w_empty;
  logic [CW-1:0] w_count;
  logic [31:0] w_free;
  logic [$bits(ipf_entry_t)-1:0] w_fifo_dout;
  ipf_entry_t  w_push_entry;
  ipf_entry_t  w_head;
  logic        w_head_zero;
  logic        w_show;
  logic        w_unused;

  assign w_unused = ^REDIRECT_PC[1:0];
  assign w_free   = 32'(FIFO_DEPTH) - 32'(w_count);

  // Next-state and push decode for the burst engine.
  always_comb begin
    w_next = r_state;
    w_push = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (EXEC && (w_free >= BURST_LEN) && !REDIRECT) w_next = S_REQ;
      end
      S_REQ: begin
        if (M_AXI_ARREADY) w_next = (r_drain_pend || REDIRECT) ? S_DRAIN : S_DATA;
      end
      S_DATA: begin
        if (M_AXI_RVALID) begin
          w_push = !REDIRECT;
          if (M_AXI_RLAST)   w_next = S_IDLE;
          else if (REDIRECT) w_next = S_DRAIN;
        end else if (REDIRECT) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (M_AXI_RVALID && M_AXI_RLAST) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, fetch address and latched AR fields. The AR address/length are
  // captured on entry to REQ so a redirect can move fa without disturbing
  // an AR that is already being presented.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state      <= S_IDLE;
      r_fa         <= RESET_PC;
      r_araddr     <= '0;
      r_arlen      <= '0;
      r_drain_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      if (REDIRECT)    r_fa <= {REDIRECT_PC[31:2], 2'b00};
      else if (w_push) r_fa <= r_fa + 32'd4;
      if ((r_state == S_IDLE) && (w_next == S_REQ)) begin
        r_araddr <= r_fa;
        r_arlen  <= burst_arlen(r_fa, BURST_LEN);
      end
      if (r_state == S_REQ) r_drain_pend <= (r_drain_pend || REDIRECT) && !M_AXI_ARREADY;
      else                  r_drain_pend <= 1'b0;
    end
  end

  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = C_M_AXI_ADDR_WIDTH'(r_araddr);
  assign M_AXI_ARLEN   = r_arlen;
  assign M_AXI_ARSIZE  = AXI_SIZE_4B;
  assign M_AXI_ARBURST = AXI_BURST_INCR;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = '0;
  assign M_AXI_ARPROT  = '0;
  assign M_AXI_ARVALID = (r_state == S_REQ);
  assign M_AXI_RREADY  = (r_state == S_DATA) || (r_state == S_DRAIN);

  assign w_push_entry.pc   = r_fa;
  assign w_push_entry.inst = M_AXI_RDATA;
  assign w_push_entry.err  = (M_AXI_RRESP != AXI_RESP_OKAY);

  ipf_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(ipf_entry_t))
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (RSTN),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .i_flush (REDIRECT),
    .o_data  (w_fifo_dout),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_head = w_fifo_dout;

`ifdef IPF_ZERO_SQUASH_EN
  assign w_head_zero = (w_head.inst == '0);
`else
  assign w_head_zero = 1'b0;
`endif

  // A squashed head is popped without stall, so it never reaches decode.
  assign w_show   = !w_empty && !w_head_zero;
  assign w_pop    = !w_empty && (w_head_zero || !STALL);
  assign I_VALID  = w_show;
  assign I_PC     = w_show ? w_head.pc   : '0;
  assign I_INST   = w_show ? w_head.inst : '0;
  assign I_ERR    = w_show && w_head.err;
  assign MEM_WAIT = RSTN && EXEC && w_empty;

endmodule

// File: tb/tb_inst_prefetch.sv
// Directed self-checking bench for inst_prefetch with a small AXI read slave
// (1-cycle latency, data = pc ^ 0x13579BDF unless forced to zero).
module tb_inst_prefetch;

  logic        CLK = 1'b0;
  logic        RSTN, EXEC, STALL, REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        MEM_WAIT, I_ERR, I_VALID;
  logic [31:0] I_PC, I_INST;
  logic [0:0]  M_AXI_ARID;
  logic [31:0] M_AXI_ARADDR;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE, M_AXI_ARPROT;
  logic [1:0]  M_AXI_ARBURST, M_AXI_RRESP;
  logic        M_AXI_ARLOCK, M_AXI_ARVALID, M_AXI_ARREADY;
  logic [3:0]  M_AXI_ARCACHE;
  logic [31:0] M_AXI_RDATA;
  logic        M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;

  inst_prefetch #(
    .C_M_AXI_THREAD_ID_WIDTH (1),
    .C_M_AXI_ADDR_WIDTH      (32),
    .FIFO_DEPTH              (16),
    .BURST_LEN               (4),
    .RESET_PC                (32'h2000_0000)
  ) dut (
    .CLK (CLK), .RSTN (RSTN), .EXEC (EXEC), .STALL (STALL),
    .REDIRECT (REDIRECT), .REDIRECT_PC (REDIRECT_PC), .MEM_WAIT (MEM_WAIT),
    .I_PC (I_PC), .I_INST (I_INST), .I_ERR (I_ERR), .I_VALID (I_VALID),
    .M_AXI_ARID (M_AXI_ARID), .M_AXI_ARADDR (M_AXI_ARADDR),
    .M_AXI_ARLEN (M_AXI_ARLEN), .M_AXI_ARSIZE (M_AXI_ARSIZE),
    .M_AXI_ARBURST (M_AXI_ARBURST), .M_AXI_ARLOCK (M_AXI_ARLOCK),
    .M_AXI_ARCACHE (M_AXI_ARCACHE), .M_AXI_ARPROT (M_AXI_ARPROT),
    .M_AXI_ARVALID (M_AXI_ARVALID), .M_AXI_ARREADY (M_AXI_ARREADY),
    .M_AXI_RDATA (M_AXI_RDATA), .M_AXI_RRESP (M_AXI_RRESP),
    .M_AXI_RLAST (M_AXI_RLAST), .M_AXI_RVALID (M_AXI_RVALID),
    .M_AXI_RREADY (M_AXI_RREADY)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic err; } out_t;

  int   errors = 0;
  int   checks = 0;
  ar_t  ar_q[$];
  ar_t  pend_q[$];
  out_t out_q[$];
  int   beats_taken = 0;
  bit   r_taken = 0;
  bit   ar_block = 0;
  bit   err_en = 0;
  logic [31:0] zero_addr = 32'h0000_0001;

  bit   sl_active = 0;
  ar_t  sl_cur;
  int   sl_beat = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == zero_addr) ? 32'h0 : (a ^ 32'h1357_9BDF);
  endfunction

  function automatic ar_t ar_at(input int i);
    ar_t z;
    z.addr = 32'hDEAD_DEAD;
    z.len  = 8'hFF;
    return (i < ar_q.size()) ? ar_q[i] : z;
  endfunction

  function automatic out_t out_at(input int i);
    out_t z;
    z.pc = 32'hDEAD_DEAD; z.inst = 32'hDEAD_DEAD; z.err = 1'bx;
    return (i < out_q.size()) ? out_q[i] : z;
  endfunction

  // Observe handshakes and accepted outputs at the active edge.
  always @(posedge CLK) begin
    if (RSTN) begin
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        ar_q.push_back('{M_AXI_ARADDR, M_AXI_ARLEN});
        pend_q.push_back('{M_AXI_ARADDR, M_AXI_ARLEN});
      end
      if (M_AXI_RVALID && M_AXI_RREADY) begin
        r_taken = 1'b1;
        beats_taken++;
      end
      if (I_VALID && !STALL && !REDIRECT) out_q.push_back('{I_PC, I_INST, I_ERR});
    end
  end

  // Read slave: one beat per cycle, first beat the cycle after AR.
  always @(negedge CLK) begin
    if (!RSTN) begin
      sl_active = 1'b0;
      r_taken   = 1'b0;
      pend_q.delete();
    end else begin
      if (r_taken) begin
        r_taken = 1'b0;
        if (sl_beat == int'(sl_cur.len)) sl_active = 1'b0;
        else sl_beat++;
      end
      if (!sl_active && pend_q.size() > 0) begin
        sl_cur    = pend_q.pop_front();
        sl_active = 1'b1;
        sl_beat   = 0;
      end
    end
    M_AXI_RVALID  = sl_active;
    M_AXI_RDATA   = sl_active ? mem_word(sl_cur.addr + 32'(4 * sl_beat)) : 32'h0;
    M_AXI_RLAST   = sl_active && (sl_beat == int'(sl_cur.len));
    M_AXI_RRESP   = (sl_active && err_en && sl_beat == 1) ? 2'b10 : 2'b00;
    M_AXI_ARREADY = !ar_block;
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic wait_ar(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && ar_q.size() < n; i++) tick();
    ok = (ar_q.size() >= n);
  endtask

  task automatic wait_out(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && out_q.size() < n; i++) tick();
    ok = (out_q.size() >= n);
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    REDIRECT    = 1'b1;
    REDIRECT_PC = pc;
    out_q.delete();
    ar_q.delete();
    tick();
    REDIRECT    = 1'b0;
  endtask

  task automatic test_reset();
    RSTN = 1'b0; EXEC = 1'b1; STALL = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = '0;
    repeat (3) tick();
    checks++;
    if (I_VALID !== 1'b0 || I_PC !== 32'h0 || I_INST !== 32'h0 || I_ERR !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: got v=%b pc=%h inst=%h err=%b want all 0", I_VALID, I_PC, I_INST, I_ERR);
    end
    checks++;
    if (M_AXI_ARVALID !== 1'b0 || M_AXI_RREADY !== 1'b0 || MEM_WAIT !== 1'b0) begin
      errors++;
      $display("FAIL reset_axi: got arvalid=%b rready=%b mem_wait=%b want 0", M_AXI_ARVALID, M_AXI_RREADY, MEM_WAIT);
    end
    EXEC = 1'b0;
    RSTN = 1'b1;
    repeat (3) tick();
    checks++;
    if (M_AXI_ARVALID !== 1'b0 || MEM_WAIT !== 1'b0) begin
      errors++;
      $display("FAIL exec_off_idle: got arvalid=%b mem_wait=%b want 0 0", M_AXI_ARVALID, MEM_WAIT);
    end
    EXEC = 1'b1;
    #1;
    checks++;
    if (MEM_WAIT !== 1'b1) begin
      errors++;
      $display("FAIL mem_wait_empty: got %b want 1", MEM_WAIT);
    end
  endtask

  task automatic test_basic();
    bit ok;
    int b0;
    out_q.delete(); ar_q.delete();
    b0 = beats_taken;
    wait_ar(1, 20, ok);
    EXEC = 1'b0;
    checks++;
    if (!ok || ar_at(0).addr !== 32'h2000_0000 || ar_at(0).len !== 8'd3) begin
      errors++;
      $display("FAIL basic_ar: got addr=%h len=%0d want 20000000 3", ar_at(0).addr, ar_at(0).len);
    end
    for (int i = 0; i < 20 && beats_taken == b0; i++) tick();
    checks++;
    if (I_VALID !== 1'b1 || I_PC !== 32'h2000_0000) begin
      errors++;
      $display("FAIL push_latency: got v=%b pc=%h want 1 20000000", I_VALID, I_PC);
    end
    wait_out(4, 30, ok);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] epc;
      epc = 32'h2000_0000 + 32'(4 * i);
      checks++;
      if (out_at(i).pc !== epc || out_at(i).inst !== mem_word(epc) || out_at(i).err !== 1'b0) begin
        errors++;
        $display("FAIL basic_out%0d: got pc=%h inst=%h err=%b want %h %h 0", i, out_at(i).pc, out_at(i).inst, out_at(i).err, epc, mem_word(epc));
      end
    end
    repeat (6) tick();
    checks++;
    if (ar_q.size() != 1 || I_VALID !== 1'b0 || MEM_WAIT !== 1'b0) begin
      errors++;
      $display("FAIL exec_stop: got ars=%0d v=%b mw=%b want 1 0 0", ar_q.size(), I_VALID, MEM_WAIT);
    end
  endtask

  task automatic test_stall();
    bit ok, seen, unstable;
    logic [31:0] fpc, finst;
    out_q.delete(); ar_q.delete();
    seen = 0; unstable = 0; fpc = '0; finst = '0;
    STALL = 1'b1; EXEC = 1'b1;
    repeat (30) begin
      tick();
      if (I_VALID) begin
        if (!seen) begin seen = 1; fpc = I_PC; finst = I_INST; end
        else if (I_PC !== fpc || I_INST !== finst) unstable = 1;
      end
    end
    checks++;
    if (!seen || unstable || I_PC !== 32'h2000_0010 || I_INST !== mem_word(32'h2000_0010)) begin
      errors++;
      $display("FAIL stall_hold: got pc=%h inst=%h unstable=%b want 20000010 stable", I_PC, I_INST, unstable);
    end
    checks++;
    if (ar_q.size() != 4 || out_q.size() != 0) begin
      errors++;
      $display("FAIL stall_fill: got ars=%0d outs=%0d want 4 0", ar_q.size(), out_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ar_at(i).addr !== 32'h2000_0010 + 32'(16 * i) || ar_at(i).len !== 8'd3) begin
        errors++;
        $display("FAIL stall_ar%0d: got %h/%0d want %h/3", i, ar_at(i).addr, ar_at(i).len, 32'h2000_0010 + 32'(16 * i));
      end
    end
    STALL = 1'b0;
    wait_out(16, 80, ok);
    for (int i = 0; i < 16; i++) begin
      logic [31:0] epc;
      epc = 32'h2000_0010 + 32'(4 * i);
      checks++;
      if (out_at(i).pc !== epc || out_at(i).inst !== mem_word(epc)) begin
        errors++;
        $display("FAIL stall_drain%0d: got pc=%h inst=%h want %h", i, out_at(i).pc, out_at(i).inst, epc);
      end
    end
    EXEC = 1'b0;
    checks++;
    if (ar_q.size() <= 4) begin
      errors++;
      $display("FAIL stall_resume: got ars=%0d want >4", ar_q.size());
    end
    repeat (40) tick();
  endtask

  task automatic test_redirect_mid();
    bit ok;
    int b0;
    out_q.delete(); ar_q.delete();
    EXEC = 1'b1;
    b0 = beats_taken;
    wait_ar(1, 20, ok);
    for (int i = 0; i < 20 && beats_taken == b0; i++) tick();
    pulse_redirect(32'h2000_0108);
    wait_ar(2, 40, ok);
    EXEC = 1'b0;
    checks++;
    if (ar_at(0).addr !== 32'h2000_0108 || ar_at(0).len !== 8'd1) begin
      errors++;
      $display("FAIL redir_ar0: got %h/%0d want 20000108/1", ar_at(0).addr, ar_at(0).len);
    end
    checks++;
    if (ar_at(1).addr !== 32'h2000_0110 || ar_at(1).len !== 8'd3) begin
      errors++;
      $display("FAIL redir_ar1: got %h/%0d want 20000110/3", ar_at(1).addr, ar_at(1).len);
    end
    wait_out(6, 40, ok);
    repeat (10) tick();
    for (int i = 0; i < 6; i++) begin
      logic [31:0] epc;
      epc = 32'h2000_0108 + 32'(4 * i);
      checks++;
      if (out_at(i).pc !== epc || out_at(i).inst !== mem_word(epc)) begin
        errors++;
        $display("FAIL redir_out%0d: got pc=%h inst=%h want %h", i, out_at(i).pc, out_at(i).inst, epc);
      end
    end
    checks++;
    if (out_q.size() != 6) begin
      errors++;
      $display("FAIL redir_count: got %0d want 6", out_q.size());
    end
  endtask

  task automatic test_redirect_arstall();
    bit ok;
    out_q.delete(); ar_q.delete();
    ar_block = 1'b1;
    EXEC = 1'b1;
    for (int i = 0; i < 20 && !M_AXI_ARVALID; i++) tick();
    checks++;
    if (M_AXI_ARVALID !== 1'b1 || M_AXI_ARADDR !== 32'h2000_0120 || M_AXI_ARLEN !== 8'd3) begin
      errors++;
      $display("FAIL arstall_req: got v=%b %h/%0d want 1 20000120/3", M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARLEN);
    end
    pulse_redirect(32'h2000_0206);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (M_AXI_ARVALID !== 1'b1 || M_AXI_ARADDR !== 32'h2000_0120 || M_AXI_ARLEN !== 8'd3 || I_VALID !== 1'b0) begin
        errors++;
        $display("FAIL arstall_hold%0d: got v=%b %h/%0d iv=%b want 1 20000120/3 0", i, M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARLEN, I_VALID);
      end
      tick();
    end
    ar_block = 1'b0;
    wait_ar(2, 40, ok);
    EXEC = 1'b0;
    checks++;
    if (ar_at(0).addr !== 32'h2000_0120 || ar_at(1).addr !== 32'h2000_0204 || ar_at(1).len !== 8'd2) begin
      errors++;
      $display("FAIL arstall_ars: got %h, %h/%0d want 20000120, 20000204/2", ar_at(0).addr, ar_at(1).addr, ar_at(1).len);
    end
    wait_out(3, 40, ok);
    repeat (10) tick();
    checks++;
    if (out_q.size() != 3 || out_at(0).pc !== 32'h2000_0204 || out_at(1).pc !== 32'h2000_0208 || out_at(2).pc !== 32'h2000_020C) begin
      errors++;
      $display("FAIL arstall_out: got n=%0d pc0=%h pc2=%h want 3 20000204 2000020c", out_q.size(), out_at(0).pc, out_at(2).pc);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    EXEC = 1'b0;
    pulse_redirect(32'hFFFF_FFF8);
    EXEC = 1'b1;
    wait_ar(2, 40, ok);
    EXEC = 1'b0;
    checks++;
    if (ar_at(0).addr !== 32'hFFFF_FFF8 || ar_at(0).len !== 8'd1) begin
      errors++;
      $display("FAIL wrap_ar0: got %h/%0d want fffffff8/1", ar_at(0).addr, ar_at(0).len);
    end
    checks++;
    if (ar_at(1).addr !== 32'h0000_0000 || ar_at(1).len !== 8'd3) begin
      errors++;
      $display("FAIL wrap_ar1: got %h/%0d want 00000000/3", ar_at(1).addr, ar_at(1).len);
    end
    wait_out(6, 40, ok);
    repeat (10) tick();
    for (int i = 0; i < 6; i++) begin
      logic [31:0] epc;
      epc = 32'hFFFF_FFF8 + 32'(4 * i);
      checks++;
      if (out_at(i).pc !== epc || out_at(i).inst !== mem_word(epc)) begin
        errors++;
        $display("FAIL wrap_out%0d: got pc=%h inst=%h want %h", i, out_at(i).pc, out_at(i).inst, epc);
      end
    end
  endtask

  task automatic test_err_zero();
    bit ok;
    logic [31:0] epc [4];
    logic        eerr [4];
    int          n;
`ifdef IPF_ZERO_SQUASH_EN
    n = 3;
    epc = '{32'h2000_0300, 32'h2000_0304, 32'h2000_030C, 32'h0};
    eerr = '{1'b0, 1'b1, 1'b0, 1'b0};
`else
    n = 4;
    epc = '{32'h2000_0300, 32'h2000_0304, 32'h2000_0308, 32'h2000_030C};
    eerr = '{1'b0, 1'b1, 1'b0, 1'b0};
`endif
    EXEC = 1'b0;
    err_en = 1'b1;
    zero_addr = 32'h2000_0308;
    pulse_redirect(32'h2000_0300);
    EXEC = 1'b1;
    wait_ar(1, 20, ok);
    EXEC = 1'b0;
    repeat (15) tick();
    checks++;
    if (out_q.size() != n) begin
      errors++;
      $display("FAIL err_count: got %0d want %0d", out_q.size(), n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (out_at(i).pc !== epc[i] || out_at(i).inst !== mem_word(epc[i]) || out_at(i).err !== eerr[i]) begin
        errors++;
        $display("FAIL err_out%0d: got pc=%h inst=%h err=%b want %h %h %b", i, out_at(i).pc, out_at(i).inst, out_at(i).err, epc[i], mem_word(epc[i]), eerr[i]);
      end
    end
    err_en = 1'b0;
    zero_addr = 32'h0000_0001;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect_mid();
    test_redirect_arstall();
    test_wrap();
    test_err_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
